// File: rtl/evolved_probe_pkg.sv
// evolved_probe_pkg: shared FSM state type and Gray-sweep helpers for the circuit prober
package evolved_probe_pkg;
   typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, REPORT, DONE} state_t;
   localparam int DEF_IN_WIDTH = 2;
   localparam int V = 1 << DEF_IN_WIDTH;
   localparam int STEP_W = $clog2(2 * V);
   function automatic logic [31:0] gray_enc(input logic [31:0] i);
      return i ^ (i >> 1);
   endfunction
   // forward half walks i = s, reverse half mirrors it back down
   function automatic logic [31:0] step_vec(input logic [31:0] s, input logic [31:0] nv);
      return gray_enc(s < nv ? s : 2 * nv - 1 - s);
   endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input
module sync_2ff (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic meta;
   always_ff @(posedge clock) begin
      if (reset) begin
         meta <= 1'b0;
         q <= 1'b0;
      end else begin
         meta <= d;
         q <= meta;
      end
   end
endmodule

// File: rtl/evolved_circuit_prober.sv
// evolved_circuit_prober: Gray-sweep stimulus and windowed response sampler for evolved circuits
module evolved_circuit_prober
   import evolved_probe_pkg::*;
#(
   parameter int IN_WIDTH = DEF_IN_WIDTH,
   parameter int SETTLE_CYCLES = 16,
   parameter int SAMPLE_COUNT = 8,
   localparam int NV = 1 << IN_WIDTH,
   localparam int SW = $clog2(2 * NV),
   localparam int OW = $clog2(SAMPLE_COUNT + 1)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic [IN_WIDTH-1:0] dut_in,
   input  logic                dut_out,
   output logic                result_valid,
   input  logic                result_ready,
   output logic [SW-1:0]       result_step,
   output logic [IN_WIDTH-1:0] result_vector,
   output logic                result_level,
   output logic                result_stable,
   output logic [OW-1:0]       result_ones,
   output logic                any_unstable
);
   // settle floor of 3 keeps the synchronizer pipeline inside the settle window
   localparam int S_EFF = SETTLE_CYCLES < 3 ? 3 : SETTLE_CYCLES;
   localparam int N_EFF = SAMPLE_COUNT < 1 ? 1 : SAMPLE_COUNT;
   localparam int CW = $clog2((S_EFF > N_EFF ? S_EFF : N_EFF) + 1);
   localparam logic [CW-1:0] S_LAST = CW'(S_EFF - 1);
   localparam logic [CW-1:0] N_LAST = CW'(N_EFF - 1);
   localparam logic [SW-1:0] STEP_LAST = SW'(2 * NV - 1);
   state_t state;
   logic [CW-1:0] cnt;
   logic [SW-1:0] step;
   logic smp, first, acc_stable, win_stable;
   logic [OW-1:0] acc_ones, win_ones;
   logic [31:0] next_vec;
   sync_2ff u_sync (.clock(clock), .reset(reset), .d(dut_out), .q(smp));
   assign win_stable = acc_stable & ((cnt == '0) | (smp == first));
   assign win_ones = acc_ones + OW'(smp);
   assign next_vec = step_vec(32'(step) + 32'd1, 32'(NV));
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         step <= '0;
         dut_in <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         first <= 1'b0;
         acc_stable <= 1'b0;
         acc_ones <= '0;
         result_valid <= 1'b0;
         result_step <= '0;
         result_vector <= '0;
         result_level <= 1'b0;
         result_stable <= 1'b0;
         result_ones <= '0;
         any_unstable <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state <= SETTLE;
               cnt <= '0;
               step <= '0;
               dut_in <= '0;
               any_unstable <= 1'b0;
               busy <= 1'b1;
            end
            SETTLE: begin
               cnt <= cnt == S_LAST ? '0 : cnt + 1'b1;
               if (cnt == S_LAST) begin
                  state <= SAMPLE;
                  acc_stable <= 1'b1;
                  acc_ones <= '0;
               end
            end
            SAMPLE: begin
               cnt <= cnt + 1'b1;
               acc_stable <= win_stable;
               acc_ones <= win_ones;
               if (cnt == '0) first <= smp;
               if (cnt == N_LAST) begin
                  state <= REPORT;
                  cnt <= '0;
                  result_valid <= 1'b1;
                  result_step <= step;
                  result_vector <= dut_in;
                  result_level <= smp;
                  result_stable <= win_stable;
                  result_ones <= win_ones;
                  any_unstable <= any_unstable | ~win_stable;
               end
            end
            REPORT: if (result_ready) begin
               result_valid <= 1'b0;
               if (step == STEP_LAST) begin
                  state <= DONE;
                  done <= 1'b1;
               end else begin
                  state <= SETTLE;
                  step <= step + 1'b1;
                  dut_in <= next_vec[IN_WIDTH-1:0];
               end
            end
            DONE: begin
               state <= IDLE;
               done <= 1'b0;
               busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_evolved_circuit_prober.sv
// tb_evolved_circuit_prober: scoreboard bench driving wire, oscillator and latch circuit models
module tb_evolved_circuit_prober;
   localparam int NSTEP = 2 * evolved_probe_pkg::V;
   typedef struct {
      int step;
      int vec;
      int level;
      int stable;
      int ones;
   } rec_t;
   logic clock = 1'b0;
   logic reset, start, busy, done, dut_out, result_valid, result_ready;
   logic result_level, result_stable, any_unstable;
   logic [1:0] dut_in, result_vector;
   logic [2:0] result_step, result_ones;
   logic osc = 1'b0, lq = 1'b0;
   int mode = 0, total = 0, bad = 0, ndone = 0;
   int vecs[8] = '{0, 1, 3, 2, 2, 3, 1, 0};
   rec_t sbq[$];
   evolved_circuit_prober #(.IN_WIDTH(2), .SETTLE_CYCLES(4), .SAMPLE_COUNT(4)) dut (
      .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
      .dut_in(dut_in), .dut_out(dut_out), .result_valid(result_valid),
      .result_ready(result_ready), .result_step(result_step), .result_vector(result_vector),
      .result_level(result_level), .result_stable(result_stable), .result_ones(result_ones),
      .any_unstable(any_unstable)
   );
   always #5 clock = ~clock;
   // latch model: vector 1 sets, vector 0 clears, anything else holds
   always @(posedge clock) begin
      osc <= ~osc;
      lq <= dut_in == 2'd1 ? 1'b1 : dut_in == 2'd0 ? 1'b0 : lq;
   end
   assign dut_out = mode == 0 ? dut_in[0] : mode == 1 ? osc : lq;
   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask
   task automatic push_sweep(input int m);
      rec_t r;
      int q = 0;
      for (int s = 0; s < NSTEP; s++) begin
         r.step = s;
         r.vec = vecs[s];
         if (vecs[s] == 1) q = 1;
         else if (vecs[s] == 0) q = 0;
         r.level = m == 0 ? vecs[s] % 2 : m == 2 ? q : -1;
         r.stable = m == 1 ? 0 : 1;
         r.ones = m == 1 ? 2 : (r.level == 1 ? 4 : 0);
         sbq.push_back(r);
      end
   endtask
   task automatic mon();
      rec_t e;
      if (done) ndone++;
      if (result_valid && result_ready) begin
         if (sbq.size() == 0) chk("sb_extra_record", 1, 0);
         else begin
            e = sbq.pop_front();
            chk("rec_step", int'(result_step), e.step);
            chk("rec_vector", int'(result_vector), e.vec);
            if (e.level >= 0) chk("rec_level", int'(result_level), e.level);
            chk("rec_stable", int'(result_stable), e.stable);
            chk("rec_ones", int'(result_ones), e.ones);
         end
      end
   endtask
   task automatic sweep(input int m, input bit bp);
      int cyc = 0;
      bit held = 0, post = 0;
      mode = m;
      ndone = 0;
      push_sweep(m);
      @(negedge clock) start = 1'b1;
      @(negedge clock) start = 1'b0;
      chk("sweep_busy", int'(busy), 1);
      while (!(ndone > 0 && !busy) && cyc < 400) begin
         @(negedge clock);
         cyc++;
         if (post) begin
            chk("bp_xfer_valid", int'(result_valid), 0);
            chk("bp_xfer_din", int'(dut_in), 2);
            post = 0;
         end
         if (bp && !held && result_valid && result_step == 3'd2) begin
            held = 1;
            result_ready = 1'b0;
            repeat (10) begin
               @(negedge clock);
               chk("bp_valid", int'(result_valid), 1);
               chk("bp_step", int'(result_step), 2);
               chk("bp_vector", int'(result_vector), 3);
               chk("bp_din", int'(dut_in), 3);
               chk("bp_ones", int'(result_ones), 4);
            end
            result_ready = 1'b1;
            post = 1;
         end
         mon();
      end
      chk("sweep_done_count", ndone, 1);
      chk("sweep_sb_left", sbq.size(), 0);
      chk("sweep_any_unstable", int'(any_unstable), m == 1 ? 1 : 0);
      chk("sweep_done_low", int'(done), 0);
      chk("sweep_din_end", int'(dut_in), 0);
   endtask
   initial begin
      int n, cyc, extra;
      reset = 1'b1;
      start = 1'b0;
      result_ready = 1'b1;
      repeat (3) @(negedge clock);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_valid", int'(result_valid), 0);
      chk("rst_din", int'(dut_in), 0);
      chk("rst_unstable", int'(any_unstable), 0);
      reset = 1'b0;
      sweep(0, 0);
      sweep(0, 1);
      sweep(1, 0);
      sweep(2, 0);
      mode = 0;
      ndone = 0;
      push_sweep(0);
      @(negedge clock) start = 1'b1;
      @(negedge clock) start = 1'b0;
      repeat (4) @(negedge clock);
      start = 1'b1;
      @(negedge clock) start = 1'b0;
      chk("ab_busy", int'(busy), 1);
      n = 0;
      while (!result_valid && n < 50) begin
         @(negedge clock);
         n++;
      end
      chk("ab_first_latency", n, 3);
      mon();
      cyc = 0;
      while (sbq.size() > 3 && cyc < 200) begin
         @(negedge clock);
         cyc++;
         mon();
      end
      chk("ab_popped", sbq.size(), 3);
      @(negedge clock);
      chk("ab_settle_valid", int'(result_valid), 0);
      chk("ab_settle_din", int'(dut_in), 3);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("ab_rst_busy", int'(busy), 0);
      chk("ab_rst_valid", int'(result_valid), 0);
      chk("ab_rst_din", int'(dut_in), 0);
      chk("ab_rst_step", int'(result_step), 0);
      extra = 0;
      repeat (30) begin
         @(negedge clock);
         if (result_valid || done || busy) extra++;
      end
      chk("ab_no_activity", extra, 0);
      chk("ab_no_done", ndone, 0);
      sbq.delete();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
